// File: rtl/async_fifo_core.sv
// Single-clock circular FIFO with watermark space flag and a registered, strobed read port.
// Optional sticky overflow output when ASYNC_FIFO_OVERFLOW_FLAG_EN is defined.
module async_fifo_core #(
   parameter int ASYNC_FIFO_MAXDATA       = 31,
   parameter int ASYNC_FIFO_MAXINDEX      = 3,
   parameter int ASYNC_FIFO_FULLTHRESHOLD = 4
) (
   input  logic                          clock,
   input  logic                          extReset,
   input  logic                          wrenb,
   input  logic [ASYNC_FIFO_MAXDATA:0]   wrdata,
   output logic                          space_avail,
   input  logic                          read_req,
   output logic                          data_avail,
   output logic                          data_valid,
`ifdef ASYNC_FIFO_OVERFLOW_FLAG_EN
   output logic                          overflow,
`endif
   output logic [ASYNC_FIFO_MAXDATA:0]   data_out
);

   localparam int DEPTH = 1 << (ASYNC_FIFO_MAXINDEX + 1);
   localparam logic [ASYNC_FIFO_MAXINDEX+1:0] C_DEPTH  = (ASYNC_FIFO_MAXINDEX+2)'(DEPTH);
   localparam logic [ASYNC_FIFO_MAXINDEX+1:0] C_THRESH = (ASYNC_FIFO_MAXINDEX+2)'(ASYNC_FIFO_FULLTHRESHOLD);
   localparam logic [ASYNC_FIFO_MAXINDEX+1:0] C_CNT1   = (ASYNC_FIFO_MAXINDEX+2)'(1);
   localparam logic [ASYNC_FIFO_MAXINDEX:0]   C_PTR1   = (ASYNC_FIFO_MAXINDEX+1)'(1);

   logic [ASYNC_FIFO_MAXDATA:0]   r_mem [DEPTH];
   logic [ASYNC_FIFO_MAXINDEX:0]  r_wptr;
   logic [ASYNC_FIFO_MAXINDEX:0]  r_rptr;
   logic [ASYNC_FIFO_MAXINDEX+1:0] r_count;
   logic                          r_data_valid;
   logic [ASYNC_FIFO_MAXDATA:0]   r_data_out;

   logic                          w_full;
   logic                          w_empty;
   logic                          w_push;
   logic                          w_pop;
   logic [ASYNC_FIFO_MAXINDEX+1:0] w_free;

   // Handshake: wrenb is accepted in any cycle the registered count is below depth and is
   // otherwise dropped; read_req pops only when count > 0, and the popped word appears on
   // data_out with data_valid high exactly one cycle later. Both decisions use the count
   // from before the edge, so an empty FIFO never falls through and a full one drops writes.
   assign w_full  = (r_count == C_DEPTH);
   assign w_empty = (r_count == '0);
   assign w_push  = wrenb && !w_full;
   assign w_pop   = read_req && !w_empty;
   assign w_free  = C_DEPTH - r_count;

   assign space_avail = (w_free >= C_THRESH);
   assign data_avail  = !w_empty;
   assign data_valid  = r_data_valid;
   assign data_out    = r_data_out;

   // RAM is not reset; data_out is only ever loaded from an entry that was written.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wptr] <= wrdata;
      end
   end

   always_ff @(posedge clock or posedge extReset) begin
      if (extReset) begin
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_data_valid <= 1'b0;
         r_data_out   <= '0;
      end else begin
         r_data_valid <= w_pop;
         if (w_push) begin
            r_wptr <= r_wptr + C_PTR1;
         end
         if (w_pop) begin
            r_rptr     <= r_rptr + C_PTR1;
            r_data_out <= r_mem[r_rptr];
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_CNT1;
            2'b01:   r_count <= r_count - C_CNT1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef ASYNC_FIFO_OVERFLOW_FLAG_EN
   logic r_overflow;

   // When full, any read_req pops, so a dropped write without a pop is wrenb && !read_req.
   always_ff @(posedge clock or posedge extReset) begin
      if (extReset) begin
         r_overflow <= 1'b0;
      end else if (wrenb && w_full && !read_req) begin
         r_overflow <= 1'b1;
      end
   end

   assign overflow = r_overflow;
`endif

endmodule

// File: tb/tb_async_fifo_core.sv
// Self-checking bench for async_fifo_core (bytes, depth 16, threshold 4) against a queue model.
module tb_async_fifo_core;

   localparam int W      = 8;
   localparam int DEPTH  = 16;
   localparam int THRESH = 4;

   logic         clock;
   logic         extReset;
   logic         wrenb;
   logic [W-1:0] wrdata;
   logic         space_avail;
   logic         read_req;
   logic         data_avail;
   logic         data_valid;
   logic [W-1:0] data_out;
`ifdef ASYNC_FIFO_OVERFLOW_FLAG_EN
   logic         overflow;
`endif

   async_fifo_core #(
      .ASYNC_FIFO_MAXDATA      (W - 1),
      .ASYNC_FIFO_MAXINDEX     (3),
      .ASYNC_FIFO_FULLTHRESHOLD(THRESH)
   ) dut (
      .clock      (clock),
      .extReset   (extReset),
      .wrenb      (wrenb),
      .wrdata     (wrdata),
      .space_avail(space_avail),
      .read_req   (read_req),
      .data_avail (data_avail),
      .data_valid (data_valid),
`ifdef ASYNC_FIFO_OVERFLOW_FLAG_EN
      .overflow   (overflow),
`endif
      .data_out   (data_out)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // scoreboard state
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_data;
   logic         exp_valid;
   logic         exp_ovf;
   int           n_cmp;
   int           n_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_flags(input string tag);
      check({tag, ".valid"}, {31'd0, data_valid}, {31'd0, exp_valid});
      check({tag, ".data"},  {24'd0, data_out},   {24'd0, exp_data});
      check({tag, ".avail"}, {31'd0, data_avail}, {31'd0, (exp_q.size() > 0)});
      check({tag, ".space"}, {31'd0, space_avail}, {31'd0, ((DEPTH - exp_q.size()) >= THRESH)});
`ifdef ASYNC_FIFO_OVERFLOW_FLAG_EN
      check({tag, ".ovf"},   {31'd0, overflow},   {31'd0, exp_ovf});
`endif
   endtask

   // driver: one clock cycle of stimulus, model update at the edge, check 1 time unit later
   task automatic step(input string tag, input logic we, input logic [W-1:0] wd, input logic rr);
      bit do_pop;
      bit do_push;
      @(negedge clock);
      wrenb    = we;
      wrdata   = wd;
      read_req = rr;
      @(posedge clock);
      do_pop  = rr && (exp_q.size() > 0);
      do_push = we && (exp_q.size() < DEPTH);
      if (we && exp_q.size() == DEPTH && !rr) exp_ovf = 1'b1;
      exp_valid = do_pop;
      if (do_pop) exp_data = exp_q.pop_front();
      if (do_push) exp_q.push_back(wd);
      #1;
      check_flags(tag);
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      wrenb    = 1'b0;
      wrdata   = '0;
      read_req = 1'b0;
      extReset = 1'b0;
      model_reset();
      #2 extReset = 1'b1;
      #1 check_flags("reset");
      @(negedge clock);
      extReset = 1'b0;

      // single word
      step("single_wr", 1'b1, 8'hA5, 1'b0);
      step("single_rd", 1'b0, 8'h00, 1'b1);
      step("single_idle", 1'b0, 8'h00, 1'b0);

      // streaming with read_req held high
      step("stream0", 1'b1, 8'h01, 1'b1);
      step("stream1", 1'b1, 8'h02, 1'b1);
      step("stream2", 1'b1, 8'h03, 1'b1);
      step("stream3", 1'b0, 8'h00, 1'b1);
      step("stream4", 1'b0, 8'h00, 1'b1);
      step("stream5", 1'b0, 8'h00, 1'b0);

      // watermark and full
      for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(8'h40 + i), 1'b0);
      step("full_drop", 1'b1, 8'hFF, 1'b0);
      step("full_rdwr", 1'b1, 8'hEE, 1'b1);
      for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1);

      // wrap-around
      for (int i = 0; i < 40; i++) begin
         step("wrap_wr", 1'b1, 8'(i * 3 + 1), 1'b0);
         step("wrap_rd", 1'b0, 8'h00, 1'b1);
      end

      // simultaneous ops
      step("sim_pre", 1'b1, 8'h10, 1'b0);
      step("sim_one", 1'b1, 8'h20, 1'b1);
      step("sim_drain", 1'b0, 8'h00, 1'b1);
      step("sim_empty", 1'b1, 8'h30, 1'b1);
      step("sim_after", 1'b0, 8'h00, 1'b1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              ($urandom_range(0, 2) == 0));
      end

      // asynchronous reset with 5 entries stored
      while (exp_q.size() > 0) step("pre_rst_drain", 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 5; i++) step("pre_rst_fill", 1'b1, 8'(8'hC0 + i), 1'b0);
      step("pre_rst_rd", 1'b0, 8'h00, 1'b1);
      step("pre_rst_wr", 1'b1, 8'hC5, 1'b0);
      @(negedge clock);
      wrenb    = 1'b0;
      read_req = 1'b0;
      #2 extReset = 1'b1;
      model_reset();
      #1 check_flags("async_rst");
      @(negedge clock);
      extReset = 1'b0;
      step("post_rst_rd", 1'b0, 8'h00, 1'b1);
      step("post_rst_wr", 1'b1, 8'h5A, 1'b0);
      step("post_rst_rd2", 1'b0, 8'h00, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
